adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request to add input1 and input2
- input1  input  32  operand A, IEEE-754 binary32
- input2  input  32  operand B, IEEE-754 binary32
- out  output  32  registered sum, IEEE-754 binary32
- busy  output  1  high while an operation is in progress
- valid  output  1  one-cycle pulse: out holds a new result
REQ-003 SHALL have no parameters.

Function
REQ-004 SHALL compute out = input1 + input2 per IEEE-754 binary32, bit-exact, round-to-nearest-ties-to-even.
REQ-005 SHALL use states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE, each lasting exactly one cycle except IDLE.
REQ-006 In IDLE, start=1 at a rising edge SHALL capture input1/input2 and move to UNPACK; start=0 keeps IDLE.
REQ-007 Sequence UNPACK->ALIGN->ADD->NORM->ROUND->DONE->IDLE SHALL be unconditional; fixed latency: accept at edge k, valid=1 after edge k+5 for exactly one cycle.
REQ-008 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-009 Operands SHALL NOT need to stay stable after the accepting edge.
REQ-010 out SHALL update only on entry to DONE and hold until the next DONE.
REQ-011 A new start SHALL be accepted at edge k+6, with no idle cycle required.
REQ-012 UNPACK: exponent 0 means subnormal (hidden bit 0, effective exponent 1); otherwise hidden bit 1.
REQ-013 ALIGN: the smaller-magnitude significand SHALL be right-shifted by the exponent difference.
- shift amounts >= 27 saturate
- all shifted-out bits OR into a sticky bit
- guard and round bits SHALL be kept
REQ-014 ADD: equal signs add magnitudes; unequal signs subtract smaller from larger; result sign = sign of larger magnitude.
REQ-015 NORM:
- carry out SHALL right-shift by 1, keeping sticky
- otherwise SHALL left-shift by leading-zero count, limited so the exponent does not fall below 1 (gradual underflow)
REQ-016 ROUND: SHALL apply RNE using guard/round/sticky.
- mantissa carry after rounding SHALL increment the exponent
- a subnormal rounding up to 2^-126 SHALL become normal
REQ-017 Overflow (biased exponent >= 255) SHALL give signed infinity.
REQ-018 Special cases:
- any NaN operand -> 32'h7FC00000
- +inf + -inf -> 32'h7FC00000
- inf + finite or same-sign inf -> that infinity
REQ-019 Exact zero result SHALL be +0, except (-0)+(-0) = -0.
REQ-020 x + (+/-0) SHALL return x exactly, including subnormal x.

Reset
REQ-021 rst=1 at a rising edge SHALL force state=IDLE, out=32'h0, busy=0, valid=0, clear internal registers, and take priority over start.
REQ-022 Reset mid-operation SHALL abort the operation with no valid pulse.
REQ-023 After rst deasserts, start SHALL be accepted at the next edge.

Verification
REQ-024 Basic add: 3F800000+3F800000 -> 40000000; valid one cycle, 6 edges after accept; busy high 6 cycles.
REQ-025 Cancellation and ties:
- 3F800000+BF800000 -> 00000000
- 3F800000+33800000 -> 3F800000
- 3F800001+33800000 -> 3F800002
REQ-026 Special values:
- 7F7FFFFF+7F7FFFFF -> 7F800000
- 7F800000+FF800000 -> 7FC00000
- 7FC00001+3F800000 -> 7FC00000
- 80000000+80000000 -> 80000000
REQ-027 Subnormals: 00000001+00000001 -> 00000002; 00800000+80000001 -> 007FFFFF.
REQ-028 Control: start pulsed while busy is ignored (one valid only); rst asserted in ALIGN -> outputs 0, no valid, next start works.
REQ-029 Regression: 10000 back-to-back random operand pairs (one-cycle start, wait valid), bit-exact against a software binary32 RNE model.

Source files
------------

// File: rtl/adder.sv
// Multi-cycle IEEE-754 binary32 adder, round-to-nearest-even.
// One stage per state: UNPACK, ALIGN, ADD, NORM, ROUND, then DONE presents the result.
module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic [31:0] out,
    output logic        busy,
    output logic        valid
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;
    logic   accept;

    logic [31:0] a_r, b_r, spec_val_r, out_r;
    logic        sgn_r, zsgn_r, sub_r, spec_r;
    logic [9:0]  exp_r;
    logic [7:0]  es_r;
    logic [23:0] mb_r, ms_r;
    logic [26:0] al_r, nm_r;
    logic [27:0] sum_r;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // DONE also accepts so back-to-back operations need no idle cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = UNPACK;
            UNPACK:  state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    state_nx = start ? UNPACK : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign out    = out_r;

    // UNPACK: order operands by magnitude, detect NaN/inf
    logic        a_big, a_nan, b_nan, a_inf, b_inf, spec_c;
    logic [31:0] big, sml, spec_v;
    always_comb begin
        a_big  = (a_r[30:0] >= b_r[30:0]);
        big    = a_big ? a_r : b_r;
        sml    = a_big ? b_r : a_r;
        a_nan  = (&a_r[30:23]) && (|a_r[22:0]);
        b_nan  = (&b_r[30:23]) && (|b_r[22:0]);
        a_inf  = (&a_r[30:23]) && !(|a_r[22:0]);
        b_inf  = (&b_r[30:23]) && !(|b_r[22:0]);
        spec_c = a_nan || b_nan || a_inf || b_inf;
        spec_v = 32'h7FC0_0000;
        if (!(a_nan || b_nan) && !(a_inf && b_inf && (a_r[31] != b_r[31])))
            spec_v = a_inf ? a_r : b_r;
    end

    // ALIGN: shift the smaller significand, jamming lost bits into sticky
    logic [7:0]  d;
    logic [26:0] ext, shifted, lost_mask, al_c;
    always_comb begin
        d         = exp_r[7:0] - es_r;
        ext       = {ms_r, 3'b000};
        shifted   = ext >> d;
        lost_mask = (27'd1 << d) - 27'd1;
        if (d >= 8'd27) al_c = {26'd0, |ms_r};
        else            al_c = shifted | {26'd0, |(ext & lost_mask)};
    end

    // NORM: carry shifts right; otherwise left-shift, clamped at exponent 1
    logic [4:0]  lz;
    logic [9:0]  lim, sh;
    logic [26:0] nm_c;
    logic [9:0]  ne_c;
    always_comb begin
        lz  = lzc27(sum_r[26:0]);
        lim = exp_r - 10'd1;
        sh  = ({5'd0, lz} > lim) ? lim : {5'd0, lz};
        if (sum_r[27]) begin
            nm_c = {sum_r[27:2], sum_r[1] | sum_r[0]};
            ne_c = exp_r + 10'd1;
        end else begin
            nm_c = sum_r[26:0] << sh;
            ne_c = exp_r - sh;
        end
    end

    // ROUND: RNE on guard/round/sticky; hidden bit picks normal vs subnormal field
    logic        rup;
    logic [24:0] mr;
    logic [9:0]  fld;
    logic [22:0] frac;
    logic [31:0] res;
    always_comb begin
        rup = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
        mr  = {1'b0, nm_r[26:3]} + {24'd0, rup};
        if (mr[24]) begin
            fld  = exp_r + 10'd1;
            frac = mr[23:1];
        end else begin
            fld  = mr[23] ? exp_r : 10'd0;
            frac = mr[22:0];
        end
        if (spec_r)              res = spec_val_r;
        else if (nm_r == 27'd0)  res = {zsgn_r, 31'd0};
        else if (fld >= 10'd255) res = {sgn_r, 8'hFF, 23'd0};
        else                     res = {sgn_r, fld[7:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0; b_r <= '0; spec_val_r <= '0; out_r <= '0;
            sgn_r <= 1'b0; zsgn_r <= 1'b0; sub_r <= 1'b0; spec_r <= 1'b0;
            exp_r <= '0; es_r <= '0; mb_r <= '0; ms_r <= '0;
            al_r <= '0; nm_r <= '0; sum_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (accept) begin
                    a_r <= input1;
                    b_r <= input2;
                end
                UNPACK: begin
                    sgn_r      <= big[31];
                    zsgn_r     <= a_r[31] & b_r[31];
                    sub_r      <= a_r[31] ^ b_r[31];
                    exp_r      <= {2'b00, (big[30:23] == 8'd0) ? 8'd1 : big[30:23]};
                    es_r       <= (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
                    mb_r       <= {|big[30:23], big[22:0]};
                    ms_r       <= {|sml[30:23], sml[22:0]};
                    spec_r     <= spec_c;
                    spec_val_r <= spec_v;
                end
                ALIGN: al_r  <= al_c;
                ADD:   sum_r <= sub_r ? ({1'b0, mb_r, 3'b000} - {1'b0, al_r})
                                      : ({1'b0, mb_r, 3'b000} + {1'b0, al_r});
                NORM: begin
                    nm_r  <= nm_c;
                    exp_r <= ne_c;
                end
                ROUND: out_r <= res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the binary32 adder: directed vectors, control cases,
// and a random regression against a double-precision reference with RNE repacking.
module tb_adder;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] input1, input2, out;
    logic        busy, valid;
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    adder dut (
        .clk(clk), .rst(rst), .start(start), .input1(input1), .input2(input2),
        .out(out), .busy(busy), .valid(valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got out=%h want no pending result", out);
            end else begin
                check("result", out, exp_q.pop_front());
            end
        end
    end

    // binary32 -> binary64 bits (exact)
    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [22:0] m;
        logic [10:0] e;
        int sh;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        if (f[30:23] != 8'd0) begin
            e = 11'(f[30:23]) + 11'd896;
            return {f[31], e, f[22:0], 29'd0};
        end
        m = f[22:0];
        sh = 0;
        while (!m[22]) begin
            m = m << 1;
            sh++;
        end
        e = 11'(896 - sh);
        return {f[31], e, m[21:0], 30'd0};
    endfunction

    // binary64 bits -> binary32 with round-to-nearest-even
    function automatic logic [31:0] d2f(input logic [63:0] d);
        int fe, shf;
        logic [63:0] m, q, rem, half;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        fe  = int'(d[62:52]) - 896;
        m   = {11'd0, 1'b1, d[51:0]};
        shf = (fe >= 1) ? 29 : 30 - fe;
        if (shf > 60) shf = 60;
        q    = m >> shf;
        rem  = m & ((64'd1 << shf) - 64'd1);
        half = 64'd1 << (shf - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (fe >= 1) begin
            if (q[24]) begin
                q = q >> 1;
                fe++;
            end
            if (fe >= 255) return {d[63], 8'hFF, 23'd0};
            return {d[63], 8'(fe), q[22:0]};
        end
        return {d[63], q[30:0]};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic an, bn, ai, bi;
        real r;
        an = (&a[30:23]) && (|a[22:0]);
        bn = (&b[30:23]) && (|b[22:0]);
        ai = (&a[30:23]) && !(|a[22:0]);
        bi = (&b[30:23]) && !(|b[22:0]);
        if (an || bn) return 32'h7FC0_0000;
        if (ai && bi) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (ai) return a;
        if (bi) return b;
        r = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
        return d2f($realtobits(r));
    endfunction

    // Called at a negedge; returns at the negedge where valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int lat, bcnt;
        exp_q.push_back(e);
        start = 1'b1; input1 = a; input2 = b;
        @(posedge clk);
        #1 start = 1'b0; input1 = $urandom; input2 = $urandom;
        lat = 0; bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (valid !== 1'b1 && lat < 20);
        check("latency", 32'(lat), 32'd6);
        check("busy_cycles", 32'(bcnt), 32'd6);
    endtask

    logic [31:0] va[15] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001,
                            32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h80000000,
                            32'h00000001, 32'h00800000, 32'h7F7FFFFF, 32'h4B000000,
                            32'h3F800000, 32'h00000001, 32'hFF800000};
    logic [31:0] vb[15] = '{32'h3F800000, 32'hBF800000, 32'h33800000, 32'h33800000,
                            32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h80000000,
                            32'h00000001, 32'h80000001, 32'h73000000, 32'h3F000000,
                            32'hC0000000, 32'h80000000, 32'h3F800000};
    logic [31:0] ve[15] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800002,
                            32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                            32'h00000002, 32'h007FFFFF, 32'h7F800000, 32'h4B000000,
                            32'hBF800000, 32'h00000001, 32'hFF800000};

    initial begin
        logic [31:0] a, b;
        int mode, ev, seen;
        rst = 1'b1; start = 1'b0; input1 = '0; input2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", out, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_op(va[i], vb[i], ve[i]);

        @(negedge clk);
        check("idle_hold_out", out, 32'hFF800000);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // start while busy must be ignored
        exp_q.push_back(32'h40400000);
        start = 1'b1; input1 = 32'h40000000; input2 = 32'h3F800000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; input1 = 32'h3F800000; input2 = 32'h3F800000;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("busy_ignore_valids", 32'(seen), 32'd1);

        // reset during ALIGN aborts with no result
        start = 1'b1; input1 = 32'h40000000; input2 = 32'h40000000;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("align_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_out", out, 32'h0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        run_op(32'h3F800000, 32'h3F800000, 32'h40000000);

        // back-to-back random regression
        for (int i = 0; i < 10000; i++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom;
            case (mode)
                0: b = $urandom;
                1: b = {1'($urandom), a[30:23], 23'($urandom)};
                2: begin
                    ev = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
                    if (ev < 0) ev = 0;
                    if (ev > 254) ev = 254;
                    b = {1'($urandom), 8'(ev), 23'($urandom)};
                end
                default: begin
                    a = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
                    b = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
                end
            endcase
            run_op(a, b, model(a, b));
        end

        repeat (10) @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
